queued_encoder: RTL and testbench
=================================

QUEUED_ENCODER -- requirements
Module: queued_encoder

Interface
REQ-001 Parameter: LSB_FIRST, default 1, service order; 1 = lowest set bit index first, 0 = highest set bit index first.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 req_in  input  8  one-hot or multi-hot request vector; bit i requests code i.
REQ-005 load  input  1  capture req_in this cycle; honoured only in IDLE.
REQ-006 busy  output  1  high in EMIT and DONE states.
REQ-007 code_out  output  3  binary index of the bit being presented; 3'd0 when code_valid low.
REQ-008 code_valid  output  1  code_out holds a valid index.
REQ-009 code_ready  input  1  consumer accepts code_out when high with code_valid.
REQ-010 done  output  1  single-cycle pulse after the final code of a vector is accepted, or after a zero vector is loaded.

Function
REQ-011 Internal state: 8-bit pending register and FSM with states IDLE, EMIT, DONE.
REQ-012 IDLE: busy=0, code_valid=0, done=0; on load=1 pending<=req_in; next state EMIT if req_in!=0, else DONE.
REQ-013 EMIT: code_valid=1; code_out = index of the first set bit of pending per LSB_FIRST, computed from the registered pending value.
REQ-014 Transfer occurs on a cycle with code_valid=1 and code_ready=1; the presented bit is cleared from pending on that edge.
REQ-015 After transfer: if remaining pending is zero, next state DONE; otherwise remain in EMIT with the next index presented the following cycle.
REQ-016 While code_valid=1 and code_ready=0, code_out and pending are held unchanged.
REQ-017 DONE: done=1, busy=1, code_valid=0 for exactly one cycle; unconditional transition to IDLE.
REQ-018 load is ignored in EMIT and DONE; req_in changes outside the load cycle have no effect.
REQ-019 Latency: load in cycle N -> first code_valid in cycle N+1; with code_ready held high, k set bits yield codes in cycles N+1..N+k, done in N+k+1, IDLE in N+k+2.
REQ-020 Throughput: one code per cycle with code_ready held high; no bubbles between codes of the same vector.
REQ-021 Each set bit of the loaded vector is emitted exactly once; no index absent from the vector is ever emitted.
REQ-022 req_in=8'hFF is a valid full load producing 8 codes; req_in=8'h00 produces no codes and done in N+1.

Reset
REQ-023 rst=1 forces state IDLE, pending=8'h00, busy=0, code_valid=0, code_out=3'd0, done=0 on the next rising edge.
REQ-024 rst takes priority over load and transfer; reset during EMIT or DONE aborts the vector with no done pulse.
REQ-025 First load is accepted in the cycle after rst deasserts.

Verification
REQ-026 LSB_FIRST=1, load 8'b1010_0100, code_ready=1 -> code_out 2,5,7 in cycles N+1..N+3; done in N+4; busy low in N+5.
REQ-027 LSB_FIRST=0, same vector -> code_out 7,5,2 in cycles N+1..N+3; done in N+4.
REQ-028 load 8'h81, code_ready low for 3 cycles after N+1 -> code_out=0 held with code_valid=1 for 4 cycles, then 7 after acceptance, done one cycle after 7 is accepted.
REQ-029 load 8'h00 -> code_valid never asserts; done pulses in N+1; busy high only in N+1.
REQ-030 load 8'hFF, second load 8'h01 asserted in cycle N+3 -> codes 0..7 only, second load ignored, done in N+9.
REQ-031 rst asserted in cycle N+2 of an 8'h0F vector -> all outputs 0 from N+3, no done pulse, next load accepted normally.

Source files
------------

// File: rtl/queued_encoder.sv
// queued_encoder: captures a multi-hot request vector and emits the index of
// each set bit over a valid/ready handshake, one index per accepted transfer.
// A single-cycle done pulse follows the last accepted code, or follows the
// load of an all-zero vector.
//
// state | meaning
// IDLE  | waiting for load; outputs quiet
// EMIT  | presenting the next pending index with code_valid high
// DONE  | one-cycle done pulse, then back to IDLE
module queued_encoder #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic       load,
  input  logic       code_ready,
  output logic       busy,
  output logic [2:0] code_out,
  output logic       code_valid,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] sel_idx;
  logic       xfer;

  // Priority pick of the next index to present from the registered pending bits.
  // The loop runs opposite to the service order so the last hit wins.
  always_comb begin
    sel_idx = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) sel_idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) sel_idx = 3'(i);
      end
    end
  end

  // A transfer needs both sides; valid is only ever high in EMIT.
  assign xfer = (state_q == EMIT) && code_ready;

  // State and pending registers; reset wins over load and transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Next-state and pending update.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          pending_d = req_in;
          state_d   = (req_in != 8'h00) ? EMIT : DONE;
        end
      end
      EMIT: begin
        if (xfer) begin
          pending_d = pending_q & ~(8'h01 << sel_idx);
          if (pending_d == 8'h00) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = 8'h00;
      end
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    busy       = 1'b0;
    code_valid = 1'b0;
    code_out   = 3'd0;
    done       = 1'b0;
    case (state_q)
      EMIT: begin
        busy       = 1'b1;
        code_valid = 1'b1;
        code_out   = sel_idx;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy       = 1'b0;
        code_valid = 1'b0;
        code_out   = 3'd0;
        done       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_queued_encoder.sv
// Directed bench for queued_encoder: one LSB-first and one MSB-first instance
// share every input so each step checks both service orders side by side.
module tb_queued_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic       load;
  logic       code_ready;

  logic       busy_l, valid_l, done_l;
  logic [2:0] code_l;
  logic       busy_m, valid_m, done_m;
  logic [2:0] code_m;

  int checks   = 0;
  int failures = 0;

  queued_encoder #(.LSB_FIRST(1'b1)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .load       (load),
    .code_ready (code_ready),
    .busy       (busy_l),
    .code_out   (code_l),
    .code_valid (valid_l),
    .done       (done_l)
  );

  queued_encoder #(.LSB_FIRST(1'b0)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .load       (load),
    .code_ready (code_ready),
    .busy       (busy_m),
    .code_out   (code_m),
    .code_valid (valid_m),
    .done       (done_m)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed as {busy, code_valid, code_out, done}.
  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed{busy,valid,code,done}=%b_%b_%0d_%b expected=%b_%b_%0d_%b",
             tag, obs[5], obs[4], obs[3:1], obs[0], exp[5], exp[4], exp[3:1], exp[0]);
    end
  endtask

  task automatic chk_l(input string tag, input logic b, input logic v, input int c, input logic d);
    chk({tag, "_lsb"}, {busy_l, valid_l, code_l, done_l}, {b, v, 3'(c), d});
  endtask

  task automatic chk_m(input string tag, input logic b, input logic v, input int c, input logic d);
    chk({tag, "_msb"}, {busy_m, valid_m, code_m, done_m}, {b, v, 3'(c), d});
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    load       = 1'b1;
    req_in     = 8'hFF;
    code_ready = 1'b1;
    step();
    step();
    chk_l("reset", 0, 0, 0, 0);
    chk_m("reset", 0, 0, 0, 0);

    // Vector 1010_0100 with ready held high: LSB 2,5,7 / MSB 7,5,2.
    rst    = 1'b0;
    load   = 1'b1;
    req_in = 8'hA4;
    chk_l("t1_idle", 0, 0, 0, 0);
    step();
    load   = 1'b0;
    req_in = 8'h5A;
    chk_l("t1_n1", 1, 1, 2, 0);
    chk_m("t1_n1", 1, 1, 7, 0);
    step();
    chk_l("t1_n2", 1, 1, 5, 0);
    chk_m("t1_n2", 1, 1, 5, 0);
    step();
    chk_l("t1_n3", 1, 1, 7, 0);
    chk_m("t1_n3", 1, 1, 2, 0);
    step();
    chk_l("t1_done", 1, 0, 0, 1);
    chk_m("t1_done", 1, 0, 0, 1);
    step();
    chk_l("t1_idle_after", 0, 0, 0, 0);
    chk_m("t1_idle_after", 0, 0, 0, 0);

    // 8'h81 with ready low for N+1..N+3: first code held four cycles.
    load       = 1'b1;
    req_in     = 8'h81;
    code_ready = 1'b0;
    step();
    load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk_l($sformatf("t2_hold%0d", i), 1, 1, 0, 0);
      chk_m($sformatf("t2_hold%0d", i), 1, 1, 7, 0);
      step();
    end
    code_ready = 1'b1;
    chk_l("t2_accept", 1, 1, 0, 0);
    chk_m("t2_accept", 1, 1, 7, 0);
    step();
    chk_l("t2_second", 1, 1, 7, 0);
    chk_m("t2_second", 1, 1, 0, 0);
    step();
    chk_l("t2_done", 1, 0, 0, 1);
    chk_m("t2_done", 1, 0, 0, 1);
    step();
    chk_l("t2_idle", 0, 0, 0, 0);

    // Zero vector: no code, done in N+1, busy only in N+1.
    load   = 1'b1;
    req_in = 8'h00;
    step();
    load = 1'b0;
    chk_l("t3_done", 1, 0, 0, 1);
    chk_m("t3_done", 1, 0, 0, 1);
    step();
    chk_l("t3_idle", 0, 0, 0, 0);
    chk_m("t3_idle", 0, 0, 0, 0);

    // Full vector with a stray load in N+3 that must be ignored.
    load   = 1'b1;
    req_in = 8'hFF;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        load   = 1'b1;
        req_in = 8'h01;
      end else begin
        load = 1'b0;
      end
      chk_l($sformatf("t4_code%0d", i), 1, 1, i, 0);
      chk_m($sformatf("t4_code%0d", i), 1, 1, 7 - i, 0);
      step();
    end
    load = 1'b0;
    chk_l("t4_done", 1, 0, 0, 1);
    chk_m("t4_done", 1, 0, 0, 1);
    step();
    chk_l("t4_idle", 0, 0, 0, 0);
    step();
    chk_l("t4_idle2", 0, 0, 0, 0);

    // Reset in N+2 of an 8'h0F vector aborts it without a done pulse.
    load   = 1'b1;
    req_in = 8'h0F;
    step();
    load = 1'b0;
    chk_l("t5_n1", 1, 1, 0, 0);
    chk_m("t5_n1", 1, 1, 3, 0);
    step();
    rst = 1'b1;
    chk_l("t5_n2", 1, 1, 1, 0);
    chk_m("t5_n2", 1, 1, 2, 0);
    step();
    rst = 1'b0;
    chk_l("t5_rst_n3", 0, 0, 0, 0);
    chk_m("t5_rst_n3", 0, 0, 0, 0);
    step();
    chk_l("t5_rst_n4", 0, 0, 0, 0);
    load   = 1'b1;
    req_in = 8'h10;
    step();
    load = 1'b0;
    chk_l("t5_reload", 1, 1, 4, 0);
    chk_m("t5_reload", 1, 1, 4, 0);
    step();
    chk_l("t5_done", 1, 0, 0, 1);
    step();
    chk_l("t5_idle", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
